// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and helpers for the clearable synchronous RAM
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } ram_state_e;

  localparam bit RAM_READ_FIRST  = 1'b1;
  localparam bit RAM_WRITE_FIRST = 1'b0;

  function automatic int unsigned ram_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - storage array with one write port and a combinational read mux
module ram_array
  import ram_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = int'(ram_depth(ADDR_W));

  // No reset on the array: the clear engine gives it a known state.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_ram_clr.sv
// rtl/sync_ram_clr.sv - synchronous single-port RAM with registered read and clear sweep
module sync_ram_clr
  import ram_pkg::*;
#(
  parameter int              DATA_W     = 4,
  parameter int              ADDR_W     = 4,
  parameter bit              READ_FIRST = RAM_READ_FIRST,
  parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WR,
  input  logic              RD,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] Data,
  input  logic              Clear,
  output logic [DATA_W-1:0] Output,
  output logic              Valid,
  output logic              Busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ram_depth(ADDR_W) - 1);

  ram_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              valid_q, valid_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (CLK),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (Address),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    out_d     = out_q;
    valid_d   = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = Address;
    mem_wdata = Data;

    unique case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = CLR_VAL;
        if (clr_ptr_q == LAST_ADDR) begin
          state_d   = IDLE;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      IDLE: begin
        // Clear wins over any access presented in the same cycle.
        if (Clear) begin
          state_d = CLEAR;
        end else begin
          mem_we = WR;
          if (RD) begin
            valid_d = 1'b1;
            out_d   = (WR && (READ_FIRST == RAM_WRITE_FIRST)) ? Data : mem_rdata;
          end
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
    end
  end

  assign Output = out_q;
  assign Valid  = valid_q;
  assign Busy   = (state_q == CLEAR);

endmodule

// File: tb/tb_sync_ram_clr.sv
// tb/tb_sync_ram_clr.sv - randomized self-checking bench for sync_ram_clr
module tb_sync_ram_clr;

  localparam logic [3:0] CLR_A = 4'h0;
  localparam logic [3:0] CLR_B = 4'h5;
  localparam logic [7:0] CLR_C = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0, rd = 1'b0, clr = 1'b0;
  logic [3:0] addr = '0, data = '0;
  logic [5:0] addr_c = '0;
  logic [7:0] data_c = '0;

  logic [3:0] out_a, out_b;
  logic [7:0] out_c;
  logic       valid_a, valid_b, valid_c;
  logic       busy_a, busy_b, busy_c;

  int vec = 0;
  int misc = 0;

  // Reference model: plain arrays plus a count of remaining sweep edges.
  logic [3:0] mem_a [16];
  logic [3:0] mem_b [16];
  logic [7:0] mem_c [64];
  int         cnt_ab, cnt_c;
  logic       ev_ab, ev_c;
  logic [3:0] eo_a, eo_b;
  logic [7:0] eo_c;

  always #5 clk = ~clk;

  sync_ram_clr u_a (
    .CLK(clk), .RST_N(rst_n), .WR(wr), .RD(rd), .Address(addr), .Data(data),
    .Clear(clr), .Output(out_a), .Valid(valid_a), .Busy(busy_a)
  );

  sync_ram_clr #(.READ_FIRST(1'b0), .CLR_VAL(CLR_B)) u_b (
    .CLK(clk), .RST_N(rst_n), .WR(wr), .RD(rd), .Address(addr), .Data(data),
    .Clear(clr), .Output(out_b), .Valid(valid_b), .Busy(busy_b)
  );

  sync_ram_clr #(.DATA_W(8), .ADDR_W(6), .CLR_VAL(CLR_C)) u_c (
    .CLK(clk), .RST_N(rst_n), .WR(wr), .RD(rd), .Address(addr_c), .Data(data_c),
    .Clear(clr), .Output(out_c), .Valid(valid_c), .Busy(busy_c)
  );

  function automatic logic [21:0] obs();
    return {busy_a, valid_a, out_a, busy_b, valid_b, out_b, busy_c, valid_c, out_c};
  endfunction

  function automatic logic [21:0] expv();
    return {cnt_ab != 0, ev_ab, eo_a, cnt_ab != 0, ev_ab, eo_b, cnt_c != 0, ev_c, eo_c};
  endfunction

  task automatic reset_model();
    cnt_ab = 16; cnt_c = 64;
    ev_ab = 1'b0; ev_c = 1'b0;
    eo_a = '0; eo_b = '0; eo_c = '0;
  endtask

  task automatic model_edge();
    if (cnt_ab != 0) begin
      cnt_ab--;
      ev_ab = 1'b0;
      if (cnt_ab == 0) foreach (mem_a[i]) begin mem_a[i] = CLR_A; mem_b[i] = CLR_B; end
    end else if (clr) begin
      cnt_ab = 16; ev_ab = 1'b0;
    end else begin
      ev_ab = rd;
      if (rd) begin
        eo_a = mem_a[addr];
        eo_b = wr ? data : mem_b[addr];
      end
      if (wr) begin mem_a[addr] = data; mem_b[addr] = data; end
    end
    if (cnt_c != 0) begin
      cnt_c--;
      ev_c = 1'b0;
      if (cnt_c == 0) foreach (mem_c[i]) mem_c[i] = CLR_C;
    end else if (clr) begin
      cnt_c = 64; ev_c = 1'b0;
    end else begin
      ev_c = rd;
      if (rd) eo_c = mem_c[addr_c];
      if (wr) mem_c[addr_c] = data_c;
    end
  endtask

  task automatic step(input logic w, input logic r, input logic c, input logic [3:0] a,
                      input logic [3:0] d, input logic [5:0] ac, input logic [7:0] dc);
    wr = w; rd = r; clr = c; addr = a; data = d; addr_c = ac; data_c = dc;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_model();
    vec++;
    if (obs() !== expv()) begin misc++; $display("FAIL reset_state: got %h want %h", obs(), expv()); end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 6'h0, 8'h0);
      vec++;
      if (busy_a !== (i < 15)) begin misc++; $display("FAIL reset_busy[%0d]: got %b want %b", i, busy_a, i < 15); end
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'(i), 4'h0, 6'(i), 8'h0);
      vec++;
      if (obs() !== expv()) begin misc++; $display("FAIL reset_read[%0d]: got %h want %h", i, obs(), expv()); end
      vec++;
      if ({valid_a, out_a} !== {1'b1, CLR_A}) begin misc++; $display("FAIL reset_read_val[%0d]: got %b/%h want 1/%h", i, valid_a, out_a, CLR_A); end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 4'(i), 4'(i), 6'(i), 8'(i));
      vec++;
      if (obs() !== expv()) begin misc++; $display("FAIL fill_write[%0d]: got %h want %h", i, obs(), expv()); end
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'(i), 4'h0, 6'(i), 8'h0);
      vec++;
      if ({valid_a, out_a, valid_b, out_b} !== {1'b1, 4'(i), 1'b1, 4'(i)}) begin
        misc++; $display("FAIL fill_read[%0d]: got %b/%h %b/%h want 1/%h", i, valid_a, out_a, valid_b, out_b, i);
      end
    end
  endtask

  task automatic test_same_cycle();
    step(1'b1, 1'b0, 1'b0, 4'h5, 4'h3, 6'h5, 8'h33);
    step(1'b1, 1'b1, 1'b0, 4'h5, 4'hA, 6'h5, 8'hAA);
    vec++;
    if (out_a !== 4'h3) begin misc++; $display("FAIL rw_read_first: got %h want 3", out_a); end
    vec++;
    if (out_b !== 4'hA) begin misc++; $display("FAIL rw_write_first: got %h want a", out_b); end
    step(1'b0, 1'b1, 1'b0, 4'h5, 4'h0, 6'h5, 8'h0);
    vec++;
    if ({out_a, out_b} !== 8'hAA) begin misc++; $display("FAIL rw_after: got %h/%h want a/a", out_a, out_b); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 4'(i), 4'hF, 6'(i), 8'hFF);
    step(1'b1, 1'b0, 1'b1, 4'h2, 4'h7, 6'h2, 8'h77);
    vec++;
    if (busy_a !== 1'b1) begin misc++; $display("FAIL clear_accept: got busy %b want 1", busy_a); end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 6'h0, 8'h0);
      vec++;
      if (busy_a !== (i < 15)) begin misc++; $display("FAIL clear_busy[%0d]: got %b want %b", i, busy_a, i < 15); end
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'(i), 4'h0, 6'(i), 8'h0);
      vec++;
      if ({out_a, out_b} !== {CLR_A, CLR_B}) begin misc++; $display("FAIL clear_read[%0d]: got %h/%h want %h/%h", i, out_a, out_b, CLR_A, CLR_B); end
    end
  endtask

  task automatic test_busy_access();
    logic [3:0] held;
    held = out_a;
    step(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 6'h0, 8'h0);
    step(1'b1, 1'b1, 1'b0, 4'h7, 4'h9, 6'h7, 8'h99);
    vec++;
    if ({valid_a, out_a} !== {1'b0, held}) begin misc++; $display("FAIL busy_access: got %b/%h want 0/%h", valid_a, out_a, held); end
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 6'h0, 8'h0);
    step(1'b0, 1'b1, 1'b0, 4'h7, 4'h0, 6'h7, 8'h0);
    vec++;
    if ({valid_a, out_a, out_b} !== {1'b1, CLR_A, CLR_B}) begin
      misc++; $display("FAIL busy_after: got %b/%h/%h want 1/%h/%h", valid_a, out_a, out_b, CLR_A, CLR_B);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 6'h0, 8'h0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 6'h0, 8'h0);
    #2 rst_n = 1'b0;
    reset_model();
    #1;
    vec++;
    if (obs() !== expv()) begin misc++; $display("FAIL reset_mid_async: got %h want %h", obs(), expv()); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 6'h0, 8'h0);
      vec++;
      if (busy_a !== (i < 15)) begin misc++; $display("FAIL reset_mid_busy[%0d]: got %b want %b", i, busy_a, i < 15); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom), 1'($urandom), ($urandom_range(39) == 0), 4'($urandom), 4'($urandom),
           6'($urandom), 8'($urandom));
      vec++;
      if (obs() !== expv()) begin misc++; $display("FAIL random[%0d]: got %h want %h", i, obs(), expv()); end
    end
  endtask

  task automatic test_param_build();
    int n;
    n = 0;
    while (busy_c !== 1'b0 && n < 80) begin
      step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 6'h0, 8'h0);
      n++;
    end
    vec++;
    if (busy_c !== 1'b0 || cnt_c != 0) begin misc++; $display("FAIL param_idle: got busy %b want 0 within 80 edges", busy_c); end
    for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 1'b0, 4'(i), 4'(i), 6'(i), 8'(i));
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'(i), 4'h0, 6'(i), 8'h0);
      vec++;
      if ({valid_c, out_c} !== {1'b1, 8'(i)}) begin misc++; $display("FAIL param_read[%0d]: got %b/%h want 1/%h", i, valid_c, out_c, 8'(i)); end
      vec++;
      if (obs() !== expv()) begin misc++; $display("FAIL param_model[%0d]: got %h want %h", i, obs(), expv()); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_same_cycle();
    test_clear();
    test_busy_access();
    test_reset_mid();
    test_random();
    test_param_build();
    $display("== %0d vectors applied, %0d miscompares ==", vec, misc);
    $finish;
  end

endmodule
